mdu_issue_ctrl: RTL and testbench

//  Issue/stall controller for the multiply/divide unit in the 5-stage pipeline.

---
 rtl/mdu_issue_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/stall controller: issues the E-stage HI/LO op and stalls D while a mult/div is in flight.
// Optional DIV0_SKIP_EN: a divide by zero is suppressed (no issue, no stall) and reported on o_div0.
`ifndef MDU_NONE
`define MDU_NONE  4'd0
`define MDU_MULT  4'd1
`define MDU_MULTU 4'd2
`define MDU_DIV   4'd3
`define MDU_DIVU  4'd4
`define MDU_MTHI  4'd5
`define MDU_MTLO  4'd6
`define MDU_MFHI  4'd7
`define MDU_MFLO  4'd8
`endif

module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_d_md_op,
  input  logic        i_e_valid,
  input  logic [3:0]  i_e_md_op,
  input  logic [31:0] i_e_rt_val,
  output logic [3:0]  o_mdu_op,
  output logic        o_stall_d,
  output logic        o_md_busy,
  output logic        o_md_done,
  output logic        o_div0,
  output logic        o_proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_md_done, w_md_done_nxt;
  logic             r_div0;
  logic             r_proto_err;

  logic w_idle, w_e_mul, w_e_div, w_div0_hit, w_issue, w_issue_start;

  assign w_idle  = (r_state == S_IDLE);
  assign w_e_mul = (i_e_md_op == `MDU_MULT) || (i_e_md_op == `MDU_MULTU);
  assign w_e_div = (i_e_md_op == `MDU_DIV)  || (i_e_md_op == `MDU_DIVU);

`ifdef DIV0_SKIP_EN
  assign w_div0_hit = i_e_valid && w_e_div && (i_e_rt_val == 32'd0);
`else
  assign w_div0_hit = 1'b0;
`endif

  assign w_issue       = w_idle && i_e_valid && !w_div0_hit;
  assign w_issue_start = w_issue && (w_e_mul || w_e_div);

  // Gated by reset so the pipeline sees a clean IDLE view while reset is held.
  assign o_mdu_op    = (w_issue && !i_reset) ? i_e_md_op : `MDU_NONE;
  assign o_stall_d   = !i_reset && (i_d_md_op != `MDU_NONE) && (!w_idle || w_issue_start);
  assign o_md_busy   = !w_idle;
  assign o_md_done   = r_md_done;
  assign o_div0      = r_div0;
  assign o_proto_err = r_proto_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_md_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue_start) begin
          if (w_e_mul) begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = CNT_W'(MUL_LAT);
          end else begin
            w_state_nxt = S_DIV;
            w_cnt_nxt   = CNT_W'(DIV_LAT);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
          w_md_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_md_done   <= 1'b0;
      r_div0      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_done <= w_md_done_nxt;
      r_div0    <= w_idle && w_div0_hit;
      // Any op presented while busy is dropped; flag it until reset.
      if (!w_idle && i_e_valid && (i_e_md_op != `MDU_NONE))
        r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: expected issued ops and busy lengths are queued at drive time.
module tb_mdu_issue_ctrl;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  d_op = OP_NONE;
  logic        e_vld = 1'b0;
  logic [3:0]  e_op = OP_NONE;
  logic [31:0] e_rt = 32'd0;
  logic [3:0]  mdu_op;
  logic        stall_d, md_busy, md_done, div0, proto_err;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  logic [3:0] exp_op_q[$];
  int         exp_lat_q[$];

  mdu_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_d_md_op(d_op), .i_e_valid(e_vld),
    .i_e_md_op(e_op), .i_e_rt_val(e_rt), .o_mdu_op(mdu_op), .o_stall_d(stall_d),
    .o_md_busy(md_busy), .o_md_done(md_done), .o_div0(div0), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every issued op and every completion is matched against queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (mdu_op != OP_NONE) begin
        if (exp_op_q.size() == 0) chk("unexpected_issue", mdu_op, OP_NONE);
        else chk("issue_op", mdu_op, exp_op_q.pop_front());
      end
      if (md_done) begin
        if (exp_lat_q.size() == 0) chk("unexpected_done", md_done, 0);
        else chk("busy_len", busy_cnt, exp_lat_q.pop_front());
      end
      busy_cnt = md_busy ? busy_cnt + 1 : 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic v, input logic [3:0] e, input logic [31:0] rt);
    d_op = d; e_vld = v; e_op = e; e_rt = rt;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && md_busy; i++) step();
    chk({tag, "_idle"}, md_busy, 0);
    @(negedge clk);
    step();
  endtask

  // Start op in E with a dependent HI/LO op in D, then check stall window and completion.
  task automatic issue_and_wait(input string tag, input logic [3:0] op, input logic [31:0] rt,
                                input int lat, input logic [3:0] dep);
    int n;
    drive(dep, 1'b1, op, rt);
    exp_op_q.push_back(op);
    exp_lat_q.push_back(lat);
    @(negedge clk);
    chk({tag, "_stall_issue"}, stall_d, 1);
    step();
    n = 0;
    for (int i = 0; i < lat; i++) begin
      drive(dep, 1'b0, OP_NONE, 0);
      @(negedge clk);
      n += int'(stall_d);
      chk({tag, "_busy"}, md_busy, 1);
      step();
    end
    @(negedge clk);
    chk({tag, "_stall_end"}, stall_d, 0);
    chk({tag, "_done"}, md_done, 1);
    chk({tag, "_stall_cycles"}, n, lat);
    step();
    drive(OP_NONE, 1'b1, dep, 0);
    exp_op_q.push_back(dep);
    @(negedge clk);
    chk({tag, "_dep_op"}, mdu_op, dep);
    chk({tag, "_done_clear"}, md_done, 0);
    step();
    drive(OP_NONE, 1'b0, OP_NONE, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    drive(OP_MFHI, 1'b1, OP_MULT, 0);
    step();
    @(negedge clk);
    chk("rst_mdu_op", mdu_op, OP_NONE);
    chk("rst_stall", stall_d, 0);
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_div0", div0, 0);
    chk("rst_proto", proto_err, 0);
    drive(OP_NONE, 1'b0, OP_NONE, 0);
    step();
    rst = 1'b0;
    step();

    issue_and_wait("mult", OP_MULT, 32'd3, 5, OP_MFLO);
    issue_and_wait("divu", OP_DIVU, 32'd7, 10, OP_MFHI);
    issue_and_wait("multu", OP_MULTU, 32'hFFFF_FFFF, 5, OP_MFHI);

    // Move ops pass straight through with no stall
    drive(OP_MFHI, 1'b1, OP_MTHI, 32'h1234);
    exp_op_q.push_back(OP_MTHI);
    @(negedge clk);
    chk("mthi_stall", stall_d, 0);
    step();
    drive(OP_NONE, 1'b1, OP_MFHI, 0);
    exp_op_q.push_back(OP_MFHI);
    @(negedge clk);
    chk("mfhi_stall", stall_d, 0);
    chk("mfhi_busy", md_busy, 0);
    step();

    // Invalid E slot never issues
    drive(OP_MFLO, 1'b0, OP_DIV, 32'd5);
    @(negedge clk);
    chk("nvld_stall", stall_d, 0);
    step();
    chk("nvld_busy", md_busy, 0);

    // Op forced into E while busy is dropped and flagged stickily
    drive(OP_NONE, 1'b1, OP_MULT, 32'd2);
    exp_op_q.push_back(OP_MULT);
    exp_lat_q.push_back(5);
    step();
    drive(OP_NONE, 1'b1, OP_MULT, 32'd2);
    @(negedge clk);
    chk("pe_dropped_op", mdu_op, OP_NONE);
    chk("pe_before", proto_err, 0);
    step();
    chk("pe_set", proto_err, 1);
    drive(OP_NONE, 1'b0, OP_MULT, 0);
    wait_idle("pe");
    chk("pe_sticky", proto_err, 1);

    // md_done cycle coincides with a new start
    drive(OP_DIV, 1'b1, OP_MULT, 0);
    exp_op_q.push_back(OP_MULT);
    exp_lat_q.push_back(5);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(OP_DIV, 1'b0, OP_NONE, 0);
      @(negedge clk);
      chk("b2b_stall", stall_d, 1);
      step();
    end
    drive(OP_NONE, 1'b1, OP_DIV, 32'd9);
    exp_op_q.push_back(OP_DIV);
    exp_lat_q.push_back(10);
    @(negedge clk);
    chk("b2b_done", md_done, 1);
    chk("b2b_op", mdu_op, OP_DIV);
    step();
    drive(OP_NONE, 1'b0, OP_NONE, 0);
    chk("b2b_busy", md_busy, 1);
    wait_idle("b2b");

    // Divide by zero
    drive(OP_NONE, 1'b1, OP_DIV, 32'd0);
`ifdef DIV0_SKIP_EN
    @(negedge clk);
    chk("div0_op", mdu_op, OP_NONE);
    step();
    drive(OP_NONE, 1'b0, OP_NONE, 0);
    chk("div0_pulse", div0, 1);
    chk("div0_busy", md_busy, 0);
    step();
    chk("div0_clear", div0, 0);
`else
    exp_op_q.push_back(OP_DIV);
    exp_lat_q.push_back(10);
    step();
    drive(OP_NONE, 1'b0, OP_NONE, 0);
    chk("div0_busy", md_busy, 1);
    chk("div0_flag", div0, 0);
    wait_idle("div0");
`endif

    // Asynchronous reset in the middle of a divide
    drive(OP_NONE, 1'b1, OP_DIVU, 32'd3);
    exp_op_q.push_back(OP_DIVU);
    exp_lat_q.push_back(10);
    step();
    drive(OP_MFHI, 1'b0, OP_NONE, 0);
    step();
    step();
    chk("arst_pre_stall", stall_d, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", md_busy, 0);
    chk("arst_stall", stall_d, 0);
    chk("arst_proto", proto_err, 0);
    exp_lat_q.delete();
    step();
    rst = 1'b0;
    drive(OP_NONE, 1'b0, OP_NONE, 0);
    step();
    chk("arst_after_busy", md_busy, 0);
    step();

    chk("op_q_empty", exp_op_q.size(), 0);
    chk("lat_q_empty", exp_lat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
